// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial sequence detector controller:
//   - state_t     : controller state encoding, also driven out on sta
//   - DEF_PAT     : reset pattern 4'b1010, zero-extended to the widest
//                   supported PAT_W; users take the low PAT_W bits
//   - PAT_W_MAX   : widest supported pattern
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam int             PAT_W_MAX = 8;
    localparam logic [PAT_W_MAX-1:0] DEF_PAT = 8'b0000_1010;

endpackage

// File: rtl/seq_det_core.sv
// ---------------------------------------------------------------------------
// seq_det_core
// Serial sample window, fill counter and pattern compare.
//
// Ports:
//   Clk    in   clock, rising edge
//   Rst    in   asynchronous active-low reset
//   i_clr  in   clear window and fill (run entry)
//   i_smp  in   accept i_bit this cycle (valid sample in RUN, no abort)
//   i_bit  in   serial data bit
//   i_ovl  in   1 = overlapping detection, 0 = restart fill after a match
//   i_pat  in   pattern, MSB is the first serial bit
//   o_hit  out  combinational: this cycle's sample completes a match
// ---------------------------------------------------------------------------
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_clr,
    input  logic             i_smp,
    input  logic             i_bit,
    input  logic             i_ovl,
    input  logic [PAT_W-1:0] i_pat,
    output logic             o_hit
);

    localparam logic [3:0] FULL = 4'(PAT_W);

    // Only the PAT_W-1 most recent bits need storing: the full window is
    // always evaluated together with the incoming bit.
    logic [PAT_W-2:0] r_win;
    logic [3:0]       r_fill;
    logic [PAT_W-1:0] w_win_nxt;
    logic [3:0]       w_fill_nxt;

    assign w_win_nxt  = {r_win, i_bit};
    assign w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 4'd1;
    assign o_hit      = i_smp && (w_fill_nxt == FULL) && (w_win_nxt == i_pat);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (i_smp) begin
            r_win  <= w_win_nxt[PAT_W-2:0];
            // Non-overlap: a fresh PAT_W bits are needed before the next hit.
            r_fill <= (o_hit && !i_ovl) ? 4'd0 : w_fill_nxt;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl
// Run controller for a serial pattern detector. Latches configuration in
// IDLE, counts pattern matches in RUN and stops in DONE when a non-zero
// target count is reached.
//
// Optional build macro: SEQ_DET_CTRL_BITCNT_EN adds bit_cnt, a saturating
// 16-bit count of samples accepted in the current/last run.
//
// Ports:
//   Clk, Rst      clock / asynchronous active-low reset
//   cfg_we        configuration write strobe (IDLE only)
//   cfg_pat       pattern, MSB first on the serial line
//   cfg_ovl       1 = overlapping detection
//   cfg_target    match count that ends the run, 0 = unbounded
//   start, abort  one-cycle run request / stop request (abort wins)
//   In_vld, In    serial sample qualifier and data (used only in RUN)
//   busy          high in RUN
//   match         one-cycle pulse, one cycle after the matching sample
//   match_cnt     matches in the current or last run (saturating)
//   done          high in DONE
//   sta           state: IDLE=0, RUN=1, DONE=2
//   bit_cnt       (macro only) accepted sample count
// ---------------------------------------------------------------------------
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic             cfg_ovl,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             In_vld,
    input  logic             In,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
`ifdef SEQ_DET_CTRL_BITCNT_EN
    output logic [15:0]      bit_cnt,
`endif
    output logic [1:0]       sta
);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;
    logic [PAT_W-1:0] r_pat;
    logic             r_ovl;
    logic [CNT_W-1:0] r_target;

    logic             w_smp;
    logic             w_clr;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    // A sample is consumed only in RUN and only when the run is not being
    // aborted in the same cycle.
    assign w_smp     = (r_state == ST_RUN) && In_vld && !abort;
    assign w_clr     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    seq_det_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .Clk   (Clk),
        .Rst   (Rst),
        .i_clr (w_clr),
        .i_smp (w_smp),
        .i_bit (In),
        .i_ovl (r_ovl),
        .i_pat (r_pat),
        .o_hit (w_hit)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_match  <= 1'b0;
            r_cnt    <= '0;
            r_pat    <= DEF_PAT[PAT_W-1:0];
            r_ovl    <= 1'b0;
            r_target <= '0;
        end else begin
            r_match <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        r_pat    <= cfg_pat;
                        r_ovl    <= cfg_ovl;
                        r_target <= cfg_target;
                    end
                    if (start && !abort) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_hit) begin
                        r_match <= 1'b1;
                        r_cnt   <= w_cnt_inc;
                        if ((r_target != '0) && (w_cnt_inc == r_target)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end else if (start) begin
                        r_state <= ST_RUN;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_DET_CTRL_BITCNT_EN
    logic [15:0] r_bit_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_bit_cnt <= '0;
        end else if (w_clr) begin
            r_bit_cnt <= '0;
        end else if (w_smp && !(&r_bit_cnt)) begin
            r_bit_cnt <= r_bit_cnt + 16'd1;
        end
    end

    assign bit_cnt = r_bit_cnt;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign sta       = r_state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_det_ctrl
// Directed scenarios with literal expectations plus a randomized phase, all
// checked every cycle against a queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_seq_det_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pat = '0;
    logic             cfg_ovl = 1'b0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             In_vld = 1'b0;
    logic             In = 1'b0;
    logic             busy, match, done;
    logic [CNT_W-1:0] match_cnt;
    logic [1:0]       sta;
`ifdef SEQ_DET_CTRL_BITCNT_EN
    logic [15:0]      bit_cnt;
`endif

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .cfg_we     (cfg_we),
        .cfg_pat    (cfg_pat),
        .cfg_ovl    (cfg_ovl),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .In_vld     (In_vld),
        .In         (In),
        .busy       (busy),
        .match      (match),
        .match_cnt  (match_cnt),
        .done       (done),
`ifdef SEQ_DET_CTRL_BITCNT_EN
        .bit_cnt    (bit_cnt),
`endif
        .sta        (sta)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 idle / 1 run / 2 done, the bits seen since
    // the last restart point kept as a queue.
    int m_mode, m_cnt, m_pat, m_ovl, m_tgt;
    bit m_match;
    bit m_hist[$];
`ifdef SEQ_DET_CTRL_BITCNT_EN
    int m_bits;
`endif

    function automatic void model_reset();
        m_mode  = 0;
        m_cnt   = 0;
        m_match = 0;
        m_hist.delete();
        m_pat   = 4'b1010;
        m_ovl   = 0;
        m_tgt   = 0;
`ifdef SEQ_DET_CTRL_BITCNT_EN
        m_bits  = 0;
`endif
    endfunction

    function automatic void enter_run();
        m_mode = 1;
        m_cnt  = 0;
        m_hist.delete();
`ifdef SEQ_DET_CTRL_BITCNT_EN
        m_bits = 0;
`endif
    endfunction

    function automatic void model_eval();
        int v;
        m_match = 0;
        case (m_mode)
            0: begin
                if (cfg_we) begin
                    m_pat = int'(cfg_pat);
                    m_ovl = int'(cfg_ovl);
                    m_tgt = int'(cfg_target);
                end
                if (start && !abort) enter_run();
            end
            1: begin
                if (abort) m_mode = 0;
                else if (In_vld) begin
`ifdef SEQ_DET_CTRL_BITCNT_EN
                    if (m_bits < 65535) m_bits++;
`endif
                    m_hist.push_back(In);
                    if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
                    if (m_hist.size() == PAT_W) begin
                        v = 0;
                        foreach (m_hist[i]) v = v * 2 + int'(m_hist[i]);
                        if (v == m_pat) begin
                            m_match = 1;
                            if (m_cnt < CMAX) m_cnt++;
                            if (m_ovl == 0) m_hist.delete();
                            if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
                        end
                    end
                end
            end
            default: begin
                if (abort) m_mode = 0;
                else if (start) enter_run();
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("sta", 32'(sta), m_mode);
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("match", 32'(match), 32'(m_match));
        chk("match_cnt", 32'(match_cnt), m_cnt);
`ifdef SEQ_DET_CTRL_BITCNT_EN
        chk("bit_cnt", 32'(bit_cnt), m_bits);
`endif
    endtask

    // One clock: model consumes the inputs the DUT is about to sample, then
    // the DUT is compared just after the edge.
    task automatic step();
        model_eval();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic configure(input logic [PAT_W-1:0] p, input logic o, input logic [CNT_W-1:0] t);
        cfg_we = 1'b1; cfg_pat = p; cfg_ovl = o; cfg_target = t;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic stop();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    // pul[i] = match seen right after sample i+1 (first sample is s[7]).
    task automatic stream(input logic [7:0] s, input bit gaps, output logic [7:0] pul);
        for (int i = 0; i < 8; i++) begin
            In_vld = 1'b1;
            In     = s[7-i];
            step();
            pul[i] = match;
            In_vld = 1'b0;
            if (gaps) begin
                In = 1'($urandom);
                step();
            end
        end
    endtask

    logic [7:0] pul;

    initial begin
        model_reset();
        #12;
        chk("rst_sta", 32'(sta), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        @(negedge Clk);
        Rst = 1'b1;

        // Reset-default pattern 1010, non-overlap
        go();
        stream(8'hAA, 1'b0, pul);
        chk("dflt_pat_pulses", 32'(pul), 32'h88);
        stop();

        // Non-overlap
        configure(4'b1010, 1'b0, '0);
        go();
        stream(8'hAA, 1'b0, pul);
        chk("nonovl_pulses", 32'(pul), 32'h88);
        chk("nonovl_cnt", 32'(match_cnt), 2);
        stop();
        chk("abort_holds_cnt", 32'(match_cnt), 2);
        chk("abort_to_idle", 32'(sta), 0);

        // Overlap
        configure(4'b1010, 1'b1, '0);
        go();
        stream(8'hAA, 1'b0, pul);
        chk("ovl_pulses", 32'(pul), 32'hA8);
        chk("ovl_cnt", 32'(match_cnt), 3);
        stop();

        // Target 2, overlap: stops after sample 6
        configure(4'b1010, 1'b1, 3'd2);
        go();
        stream(8'hAA, 1'b0, pul);
        chk("tgt_pulses", 32'(pul), 32'h28);
        chk("tgt_done", 32'(done), 1);
        chk("tgt_sta", 32'(sta), 2);
        chk("tgt_cnt", 32'(match_cnt), 2);
        stop();

        // In_vld gaps between every bit
        configure(4'b1010, 1'b0, '0);
        go();
        stream(8'hAA, 1'b1, pul);
        chk("gap_pulses", 32'(pul), 32'h88);
        chk("gap_cnt", 32'(match_cnt), 2);
        stop();

        // start+abort in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(sta), 0);

        // cfg_we during RUN ignored: old 1010 still used, not 0110
        configure(4'b1010, 1'b0, '0);
        go();
        cfg_we = 1'b1; cfg_pat = 4'b0110;
        step();
        cfg_we = 1'b0;
        stream(8'b0110_1010, 1'b0, pul);
        chk("cfg_in_run_pulses", 32'(pul), 32'h20);
        stop();

        // Reset while a match pulse is out
        configure(4'b1010, 1'b0, '0);
        go();
        stream(8'b0000_1010, 1'b0, pul);
        chk("pre_rst_match", 32'(match), 1);
        In_vld = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        chk("midrst_match", 32'(match), 0);
        chk("midrst_sta", 32'(sta), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cnt", 32'(match_cnt), 0);
        model_reset();
        Rst = 1'b1;
        step();
        chk("post_rst_idle", 32'(sta), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_pat    = PAT_W'($urandom);
            cfg_ovl    = 1'($urandom);
            cfg_target = CNT_W'($urandom_range(0, 4));
            start      = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            In_vld     = ($urandom_range(0, 9) < 7);
            In         = 1'($urandom);
            step();
        end
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0; In_vld = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..8.
REQ-002 Parameter CNT_W, default 8: match-counter and target width.
REQ-003 Clk  input  1  clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 cfg_we  input  1  configuration write strobe, honoured only in IDLE.
REQ-006 cfg_pat  input  PAT_W  pattern to detect; MSB is the first serial bit.
REQ-007 cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 cfg_target  input  CNT_W  match count ending the run; 0 = unbounded.
REQ-009 start  input  1  one-cycle run request.
REQ-010 abort  input  1  one-cycle stop request.
REQ-011 In_vld  input  1  serial bit valid qualifier.
REQ-012 In  input  1  serial data bit.
REQ-013 busy  output  1  high while in RUN.
REQ-014 match  output  1  registered one-cycle pulse per detected pattern.
REQ-015 match_cnt  output  CNT_W  matches in the current or last run.
REQ-016 done  output  1  high while in DONE.
REQ-017 sta  output  2  encoded controller state: IDLE=0, RUN=1, DONE=2.

Function
REQ-018 Controller FSM states IDLE, RUN, DONE; state 3 unreachable, recovers to IDLE next cycle.
REQ-019 IDLE: cfg_we=1 latches cfg_pat, cfg_ovl, cfg_target into internal registers; start=1 -> RUN.
REQ-020 Entering RUN clears match_cnt, the sample window and the fill counter in the same edge.
REQ-021 RUN: each cycle with In_vld=1 shifts In into a PAT_W-bit window; fill counter increments, saturating at PAT_W.
REQ-022 Match condition: In_vld=1 and fill (including the current bit) = PAT_W and window (including the current bit) = latched pattern.
REQ-023 match asserts on the edge following the matching sample, for exactly one cycle; latency 1 cycle.
REQ-024 On a match, overlap mode keeps the window and fill; non-overlap mode resets fill to 0.
REQ-025 In_vld=0 cycles: window, fill and count hold.
REQ-026 match_cnt increments on each match, saturating at 2^CNT_W-1.
REQ-027 RUN -> DONE on the edge where the incremented count equals a non-zero target; match still pulses.
REQ-028 abort=1 in RUN -> IDLE; match_cnt holds its value, no match pulse for that cycle's sample.
REQ-029 start and abort together in any state: abort wins; FSM goes to or stays in IDLE.
REQ-030 DONE: holds match_cnt; start -> RUN (restart with the same configuration); abort -> IDLE.
REQ-031 cfg_we outside IDLE is ignored; start in RUN is ignored.
REQ-032 In and In_vld are ignored outside RUN.

Reset
REQ-033 Rst low: state IDLE, busy=0, match=0, done=0, match_cnt=0, window=0, fill=0.
REQ-034 Rst low: configuration resets to pattern 4'b1010 (PAT_W'b1010... truncated/zero-padded to PAT_W), overlap=0, target=0.
REQ-035 Reset mid-run aborts immediately with no pending match pulse; the first edge after release evaluates from IDLE.

Configuration
REQ-036 Macro SEQ_DET_CTRL_BITCNT_EN defined: adds output bit_cnt (16 bits), counts In_vld samples accepted in RUN, saturating, cleared on entering RUN and by reset.
REQ-037 Macro undefined: bit_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-038 Shared package seq_det_pkg holds the controller state enum (IDLE/RUN/DONE encodings) and the default pattern constant.
REQ-039 Sub-module seq_det_core holds the window, fill counter, match compare and overlap handling; seq_det_ctrl holds the FSM, configuration registers and counters.

Verification
REQ-040 Non-overlap, pattern 1010, stream 1,0,1,0,1,0,1,0 -> 2 match pulses, after samples 4 and 8; match_cnt=2.
REQ-041 Overlap, same stream -> 3 pulses, after samples 4, 6 and 8; match_cnt=3.
REQ-042 Target=2, overlap, same stream -> DONE after sample 6; done=1; sample 7 onward ignored; match_cnt stays 2.
REQ-043 In_vld gaps inserted between every bit of test REQ-040 -> identical pulse count, each pulse 1 cycle after its qualifying sample.
REQ-044 abort together with start in IDLE -> stays IDLE; cfg_we in RUN with a new pattern -> old pattern still used.
REQ-045 Rst asserted mid-run, during the cycle a match is pending -> match=0 and all outputs reset immediately; sta=0.
